// File: rtl/cordic_phase_fold_if.sv
// Handshake bundle between the phase folder (master) and the downstream cordic_rtl core (slave).
interface cordic_phase_fold_if;
    logic        core_start;
    logic [11:0] core_angle;
    logic        core_ready;
    logic [11:0] core_sin;
    logic [11:0] core_cos;

    modport master (
        output core_start,
        output core_angle,
        input  core_ready,
        input  core_sin,
        input  core_cos
    );

    modport slave (
        input  core_start,
        input  core_angle,
        output core_ready,
        output core_sin,
        output core_cos
    );
endinterface

// File: rtl/cordic_phase_fold.sv
// Folds a signed [-pi, +pi] phase into the first quadrant for a cordic_rtl core and restores result signs.
// Optional macro CORDIC_RANGE_CHECK_EN adds err_out and rejects |phase_in| > PI instead of saturating it.
module cordic_phase_fold #(
    parameter int ITER_TIMEOUT = 63
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic signed [12:0]  phase_in,
    cordic_phase_fold_if.master core,
    output logic                ready_out,
    output logic signed [12:0]  sin_out,
    output logic signed [12:0]  cos_out
`ifdef CORDIC_RANGE_CHECK_EN
    ,
    output logic                err_out
`endif
);

    localparam logic [12:0] PI          = 13'd3217;
    localparam logic [12:0] HALF_PI     = 13'd1608;
    localparam logic [5:0]  TIMEOUT_CNT = 6'(ITER_TIMEOUT);

    typedef enum logic [2:0] {IDLE, FOLD, KICK, WAIT, FIX} state_t;

    state_t             r_state;
    logic signed [12:0] r_phase;
    logic               r_coreStart;
    logic [11:0]        r_coreAngle;
    logic [5:0]         r_count;
    logic               r_sinNeg;
    logic               r_cosNeg;
    logic [11:0]        r_sinMag;
    logic [11:0]        r_cosMag;
    logic               r_readyOut;
    logic signed [12:0] r_sinOut;
    logic signed [12:0] r_cosOut;
`ifdef CORDIC_RANGE_CHECK_EN
    logic               r_errPending;
    logic               r_err;
`endif

    logic [12:0] w_abs;
    logic [12:0] w_sat;
    logic        w_outOfRange;
    logic        w_cosNeg;
    logic [11:0] w_foldAngle;

    // Magnitude is 13 bits wide so that -4096 folds without overflow.
    always_comb begin
        w_abs        = r_phase[12] ? $unsigned(-r_phase) : $unsigned(r_phase);
        w_outOfRange = (w_abs > PI);
        w_sat        = w_outOfRange ? PI : w_abs;
        w_cosNeg     = (w_sat > HALF_PI);
        w_foldAngle  = w_cosNeg ? 12'(PI - w_sat) : w_sat[11:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_phase     <= '0;
            r_coreStart <= 1'b0;
            r_coreAngle <= '0;
            r_count     <= '0;
            r_sinNeg    <= 1'b0;
            r_cosNeg    <= 1'b0;
            r_sinMag    <= '0;
            r_cosMag    <= '0;
            r_readyOut  <= 1'b0;
            r_sinOut    <= '0;
            r_cosOut    <= '0;
`ifdef CORDIC_RANGE_CHECK_EN
            r_errPending <= 1'b0;
            r_err        <= 1'b0;
`endif
        end else begin
            r_coreStart <= 1'b0;
            r_readyOut  <= 1'b0;
`ifdef CORDIC_RANGE_CHECK_EN
            r_err       <= 1'b0;
`endif
            case (r_state)
                // A start coinciding with the previous result pulse is dropped.
                IDLE: begin
                    if (start && !r_readyOut) begin
                        r_phase <= phase_in;
                        r_state <= FOLD;
                    end
                end
                FOLD: begin
                    r_sinNeg <= r_phase[12];
                    r_cosNeg <= w_cosNeg;
`ifdef CORDIC_RANGE_CHECK_EN
                    if (w_outOfRange) begin
                        r_coreAngle  <= '0;
                        r_sinMag     <= '0;
                        r_cosMag     <= '0;
                        r_errPending <= 1'b1;
                        r_state      <= FIX;
                    end else begin
                        r_coreAngle  <= w_foldAngle;
                        r_coreStart  <= 1'b1;
                        r_errPending <= 1'b0;
                        r_state      <= KICK;
                    end
`else
                    r_coreAngle <= w_foldAngle;
                    r_coreStart <= 1'b1;
                    r_state     <= KICK;
`endif
                end
                KICK: begin
                    r_count <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (core.core_ready) begin
                        r_sinMag <= core.core_sin;
                        r_cosMag <= core.core_cos;
                        r_count  <= '0;
                        r_state  <= FIX;
                    end else if (r_count + 6'd1 == TIMEOUT_CNT) begin
                        r_sinMag <= '0;
                        r_cosMag <= '0;
                        r_count  <= '0;
`ifdef CORDIC_RANGE_CHECK_EN
                        r_errPending <= 1'b1;
`endif
                        r_state  <= FIX;
                    end else begin
                        r_count <= r_count + 6'd1;
                    end
                end
                FIX: begin
                    r_sinOut   <= r_sinNeg ? -$signed({1'b0, r_sinMag}) : $signed({1'b0, r_sinMag});
                    r_cosOut   <= r_cosNeg ? -$signed({1'b0, r_cosMag}) : $signed({1'b0, r_cosMag});
                    r_readyOut <= 1'b1;
`ifdef CORDIC_RANGE_CHECK_EN
                    r_err      <= r_errPending;
`endif
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign core.core_start = r_coreStart;
    assign core.core_angle = r_coreAngle;
    assign ready_out       = r_readyOut;
    assign sin_out         = r_sinOut;
    assign cos_out         = r_cosOut;
`ifdef CORDIC_RANGE_CHECK_EN
    assign err_out         = r_err;
`endif

endmodule

// File: tb/tb_cordic_phase_fold.sv
// Self-checking bench for cordic_phase_fold with a behavioural cordic core responder and a
// quadrant-folding reference model; honours CORDIC_RANGE_CHECK_EN when it is defined.
module tb_cordic_phase_fold;

    localparam int ITER_TIMEOUT = 63;
    localparam int PI           = 3217;
    localparam int HALF_PI      = 1608;

    logic               clock = 1'b0;
    logic               reset;
    logic               start;
    logic signed [12:0] phase_in;
    logic               ready_out;
    logic signed [12:0] sin_out;
    logic signed [12:0] cos_out;
`ifdef CORDIC_RANGE_CHECK_EN
    logic               err_out;
`endif

    cordic_phase_fold_if coreIf ();

    cordic_phase_fold #(.ITER_TIMEOUT(ITER_TIMEOUT)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .phase_in (phase_in),
        .core     (coreIf.master),
        .ready_out(ready_out),
        .sin_out  (sin_out),
        .cos_out  (cos_out)
`ifdef CORDIC_RANGE_CHECK_EN
        ,
        .err_out  (err_out)
`endif
    );

    always #5 clock = ~clock;

    int          checkCount = 0;
    int          failCount  = 0;
    int          kickCount  = 0;
    int          readyCount = 0;
    int          coreLatency = 16;
    bit          coreMute    = 1'b0;
    logic [11:0] coreSinVal  = '0;
    logic [11:0] coreCosVal  = '0;
    logic [11:0] kickAngle   = '0;
    logic [11:0] readyAngle  = '0;

    // Event counters observed mid-cycle, away from the active edge.
    always @(negedge clock) begin
        if (coreIf.core_start === 1'b1) kickCount++;
        if (ready_out === 1'b1) readyCount++;
    end

    // Behavioural core: answers coreLatency cycles after each kick unless muted.
    initial begin
        coreIf.core_ready = 1'b0;
        coreIf.core_sin   = '0;
        coreIf.core_cos   = '0;
        forever begin
            @(negedge clock);
            if (coreIf.core_start === 1'b1) begin
                kickAngle = coreIf.core_angle;
                if (!coreMute) begin
                    repeat (coreLatency) @(negedge clock);
                    readyAngle        = coreIf.core_angle;
                    coreIf.core_sin   = coreSinVal;
                    coreIf.core_cos   = coreCosVal;
                    coreIf.core_ready = 1'b1;
                    @(negedge clock);
                    coreIf.core_ready = 1'b0;
                end
            end
        end
    end

    // Reference: reflect the angle into [0, pi/2] and work out result signs from the quadrant.
    function automatic void refFold(input int phase, output int angle, output bit sNeg,
                                    output bit cNeg, output bit err);
        int a;
        a    = (phase < 0) ? -phase : phase;
        sNeg = (phase < 0);
        err  = 1'b0;
        if (a > PI) begin
`ifdef CORDIC_RANGE_CHECK_EN
            err = 1'b1;
`else
            a = PI;
`endif
        end
        cNeg  = (a > HALF_PI);
        angle = cNeg ? (PI - a) : a;
    endfunction

    // One request: pulse start, then wait (bounded) for the result pulse.
    task automatic applyStimulus(input int ph, input int lat, input bit mute, input int sMag,
                                 input int cMag, output int cycles, output bit gotReady,
                                 output int gotSin, output int gotCos, output bit gotErr);
        coreLatency = lat;
        coreMute    = mute;
        coreSinVal  = 12'(sMag);
        coreCosVal  = 12'(cMag);
        @(negedge clock);
        phase_in = 13'(ph);
        start    = 1'b1;
        @(negedge clock);
        start  = 1'b0;
        cycles = 1;
        while (ready_out !== 1'b1 && cycles < 200) begin
            @(negedge clock);
            cycles++;
        end
        gotReady = (ready_out === 1'b1);
        gotSin   = int'(sin_out);
        gotCos   = int'(cos_out);
`ifdef CORDIC_RANGE_CHECK_EN
        gotErr   = err_out;
`else
        gotErr   = 1'b0;
`endif
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        start    = 1'b1;
        phase_in = 13'sd717;
        repeat (4) @(negedge clock);
        checkCount++;
        if (ready_out !== 1'b0) begin failCount++; $display("[TB] FAIL reset ready_out: got %b expected 0", ready_out); end
        checkCount++;
        if (coreIf.core_start !== 1'b0) begin failCount++; $display("[TB] FAIL reset core_start: got %b expected 0", coreIf.core_start); end
        checkCount++;
        if (coreIf.core_angle !== 12'd0) begin failCount++; $display("[TB] FAIL reset core_angle: got %0d expected 0", coreIf.core_angle); end
        checkCount++;
        if (sin_out !== 13'sd0 || cos_out !== 13'sd0) begin failCount++; $display("[TB] FAIL reset outputs: got sin %0d cos %0d expected 0 0", sin_out, cos_out); end
        checkCount++;
        if (kickCount !== 0) begin failCount++; $display("[TB] FAIL reset kicks: got %0d expected 0", kickCount); end
`ifdef CORDIC_RANGE_CHECK_EN
        checkCount++;
        if (err_out !== 1'b0) begin failCount++; $display("[TB] FAIL reset err_out: got %b expected 0", err_out); end
`endif
        start = 1'b0;
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_directed();
        int dirPhase[10] = '{717, -717, 2500, -2500, 0, 1608, -1608, 1609, 3217, -3217};
        int cycles, gotSin, gotCos, expAngle, expSin, expCos, kicksBefore;
        bit gotReady, gotErr, sNeg, cNeg, err;
        foreach (dirPhase[i]) begin
            refFold(dirPhase[i], expAngle, sNeg, cNeg, err);
            expSin = sNeg ? -660 : 660;
            expCos = cNeg ? -783 : 783;
            kicksBefore = kickCount;
            applyStimulus(dirPhase[i], 16, 1'b0, 660, 783, cycles, gotReady, gotSin, gotCos, gotErr);
            checkCount++;
            if (!gotReady || cycles != 20) begin failCount++; $display("[TB] FAIL directed latency phase=%0d: got %0d cycles (ready %b) expected 20", dirPhase[i], cycles, gotReady); end
            checkCount++;
            if (kickCount - kicksBefore != 1) begin failCount++; $display("[TB] FAIL directed kicks phase=%0d: got %0d expected 1", dirPhase[i], kickCount - kicksBefore); end
            checkCount++;
            if (int'(kickAngle) != expAngle || int'(readyAngle) != expAngle) begin failCount++; $display("[TB] FAIL directed angle phase=%0d: got %0d/%0d expected %0d", dirPhase[i], kickAngle, readyAngle, expAngle); end
            checkCount++;
            if (gotSin != expSin) begin failCount++; $display("[TB] FAIL directed sin phase=%0d: got %0d expected %0d", dirPhase[i], gotSin, expSin); end
            checkCount++;
            if (gotCos != expCos) begin failCount++; $display("[TB] FAIL directed cos phase=%0d: got %0d expected %0d", dirPhase[i], gotCos, expCos); end
        end
    endtask

    task automatic test_random();
        int ph, lat, sMag, cMag, cycles, gotSin, gotCos, expAngle, expSin, expCos;
        bit gotReady, gotErr, sNeg, cNeg, err;
        for (int n = 0; n < 12; n++) begin
            ph   = int'($urandom_range(0, 2 * PI)) - PI;
            lat  = int'($urandom_range(1, 20));
            sMag = int'($urandom_range(0, 4095));
            cMag = int'($urandom_range(0, 4095));
            refFold(ph, expAngle, sNeg, cNeg, err);
            expSin = sNeg ? -sMag : sMag;
            expCos = cNeg ? -cMag : cMag;
            applyStimulus(ph, lat, 1'b0, sMag, cMag, cycles, gotReady, gotSin, gotCos, gotErr);
            checkCount++;
            if (!gotReady || cycles != lat + 4) begin failCount++; $display("[TB] FAIL random latency phase=%0d: got %0d expected %0d", ph, cycles, lat + 4); end
            checkCount++;
            if (int'(kickAngle) != expAngle || int'(readyAngle) != expAngle) begin failCount++; $display("[TB] FAIL random angle phase=%0d: got %0d/%0d expected %0d", ph, kickAngle, readyAngle, expAngle); end
            checkCount++;
            if (gotSin != expSin || gotCos != expCos) begin failCount++; $display("[TB] FAIL random result phase=%0d: got %0d,%0d expected %0d,%0d", ph, gotSin, gotCos, expSin, expCos); end
        end
    endtask

    task automatic test_range();
        int cycles, gotSin, gotCos, kicksBefore;
        bit gotReady, gotErr;
        kicksBefore = kickCount;
`ifdef CORDIC_RANGE_CHECK_EN
        applyStimulus(3300, 16, 1'b0, 0, 1024, cycles, gotReady, gotSin, gotCos, gotErr);
        checkCount++;
        if (!gotReady || cycles != 3) begin failCount++; $display("[TB] FAIL range latency: got %0d expected 3", cycles); end
        checkCount++;
        if (gotErr !== 1'b1) begin failCount++; $display("[TB] FAIL range err_out: got %b expected 1", gotErr); end
        checkCount++;
        if (gotSin != 0 || gotCos != 0) begin failCount++; $display("[TB] FAIL range result: got %0d,%0d expected 0,0", gotSin, gotCos); end
        checkCount++;
        if (kickCount != kicksBefore) begin failCount++; $display("[TB] FAIL range kicks: got %0d expected 0", kickCount - kicksBefore); end
`else
        applyStimulus(3300, 16, 1'b0, 0, 1024, cycles, gotReady, gotSin, gotCos, gotErr);
        checkCount++;
        if (!gotReady || kickAngle !== 12'd0) begin failCount++; $display("[TB] FAIL range angle: got %0d (ready %b) expected 0", kickAngle, gotReady); end
        checkCount++;
        if (gotSin != 0 || gotCos != -1024) begin failCount++; $display("[TB] FAIL range result: got %0d,%0d expected 0,-1024", gotSin, gotCos); end
        applyStimulus(-4096, 5, 1'b0, 7, 1024, cycles, gotReady, gotSin, gotCos, gotErr);
        checkCount++;
        if (!gotReady || gotSin != -7 || gotCos != -1024) begin failCount++; $display("[TB] FAIL range min result: got %0d,%0d expected -7,-1024", gotSin, gotCos); end
        checkCount++;
        if (kickCount - kicksBefore != 2) begin failCount++; $display("[TB] FAIL range kicks: got %0d expected 2", kickCount - kicksBefore); end
`endif
    endtask

    task automatic test_timeout();
        int cycles, gotSin, gotCos;
        bit gotReady, gotErr;
        applyStimulus(717, 3, 1'b0, 660, 783, cycles, gotReady, gotSin, gotCos, gotErr);
        applyStimulus(717, 1, 1'b1, 660, 783, cycles, gotReady, gotSin, gotCos, gotErr);
        checkCount++;
        if (!gotReady || cycles < ITER_TIMEOUT + 3 || cycles > ITER_TIMEOUT + 4) begin failCount++; $display("[TB] FAIL timeout latency: got %0d (ready %b) expected %0d..%0d", cycles, gotReady, ITER_TIMEOUT + 3, ITER_TIMEOUT + 4); end
        checkCount++;
        if (gotSin != 0 || gotCos != 0) begin failCount++; $display("[TB] FAIL timeout result: got %0d,%0d expected 0,0", gotSin, gotCos); end
`ifdef CORDIC_RANGE_CHECK_EN
        checkCount++;
        if (gotErr !== 1'b1) begin failCount++; $display("[TB] FAIL timeout err_out: got %b expected 1", gotErr); end
`endif
        coreMute = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        int cycles, gotSin, gotCos, readyBefore;
        bit gotReady, gotErr;
        applyStimulus(-2500, 4, 1'b0, 660, 783, cycles, gotReady, gotSin, gotCos, gotErr);
        coreLatency = 16;
        @(negedge clock);
        phase_in = 13'sd717;
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (7) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        readyBefore = readyCount;
        repeat (30) @(negedge clock);
        #2;
        checkCount++;
        if (readyCount != readyBefore) begin failCount++; $display("[TB] FAIL midreset ready pulses: got %0d expected 0", readyCount - readyBefore); end
        checkCount++;
        if (sin_out !== 13'sd0 || cos_out !== 13'sd0 || coreIf.core_angle !== 12'd0) begin failCount++; $display("[TB] FAIL midreset outputs: got %0d,%0d angle %0d expected 0,0,0", sin_out, cos_out, coreIf.core_angle); end
        applyStimulus(2500, 2, 1'b0, 660, 783, cycles, gotReady, gotSin, gotCos, gotErr);
        checkCount++;
        if (!gotReady || cycles != 6 || gotSin != 660 || gotCos != -783) begin failCount++; $display("[TB] FAIL midreset recovery: got %0d cycles %0d,%0d expected 6 660,-783", cycles, gotSin, gotCos); end
    endtask

    task automatic test_back_to_back();
        int cycles, gotSin, gotCos, kicksBefore;
        bit gotReady, gotErr;
        applyStimulus(717, 3, 1'b0, 660, 783, cycles, gotReady, gotSin, gotCos, gotErr);
        kicksBefore = kickCount;
        phase_in = 13'sd717;
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (12) @(negedge clock);
        checkCount++;
        if (kickCount != kicksBefore) begin failCount++; $display("[TB] FAIL b2b ignored start: got %0d kicks expected 0", kickCount - kicksBefore); end
        applyStimulus(1000, 3, 1'b0, 5, 6, cycles, gotReady, gotSin, gotCos, gotErr);
        applyStimulus(-1000, 3, 1'b0, 9, 10, cycles, gotReady, gotSin, gotCos, gotErr);
        checkCount++;
        if (!gotReady || cycles != 7 || gotSin != -9 || gotCos != 10) begin failCount++; $display("[TB] FAIL b2b accepted start: got %0d cycles %0d,%0d expected 7 -9,10", cycles, gotSin, gotCos); end
    endtask

    task automatic test_start_held();
        int kicksBefore, readyBefore, expAccepts, period;
        coreLatency = 4;
        coreMute    = 1'b0;
        coreSinVal  = 12'd660;
        coreCosVal  = 12'd783;
        period      = coreLatency + 5;
        expAccepts  = 0;
        for (int k = 0; k < 30; k += period) expAccepts++;
        @(negedge clock);
        kicksBefore = kickCount;
        readyBefore = readyCount;
        phase_in = 13'sd717;
        start    = 1'b1;
        repeat (30) @(negedge clock);
        start = 1'b0;
        repeat (40) @(negedge clock);
        #2;
        checkCount++;
        if (kickCount - kicksBefore != expAccepts) begin failCount++; $display("[TB] FAIL held kicks: got %0d expected %0d", kickCount - kicksBefore, expAccepts); end
        checkCount++;
        if (readyCount - readyBefore != expAccepts) begin failCount++; $display("[TB] FAIL held ready pulses: got %0d expected %0d", readyCount - readyBefore, expAccepts); end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        phase_in = '0;
        $display("[TB] cordic_phase_fold bench starting");
        test_reset();
        test_directed();
        test_random();
        test_range();
        test_timeout();
        test_reset_mid_wait();
        test_back_to_back();
        test_start_held();
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/cordic_phase_fold.md
CORDIC_PHASE_FOLD -- requirements
Module: cordic_phase_fold

Interface
REQ-001 SHALL have parameter ITER_TIMEOUT, default 63, the maximum cycles to wait for the core's ready_out before aborting.
REQ-002 SHALL have port clock  in  1  the single system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port start  in  1  request pulse; sampled only in IDLE.
REQ-005 SHALL have port phase_in  in  13  signed two's complement angle, 10 fraction bits (radians), valid range [-pi, +pi].
REQ-006 SHALL have port core_start  out  1  start to the downstream cordic_rtl core.
REQ-007 SHALL have port core_angle  out  12  folded angle to the core, unsigned Q2.10, range [0, pi/2].
REQ-008 SHALL have port core_ready  in  1  ready_out from the core.
REQ-009 SHALL have port core_sin, core_cos  in  12 each  unsigned Q2.10 magnitudes from the core.
REQ-010 SHALL have port ready_out  out  1  one-cycle result-valid pulse.
REQ-011 SHALL have port sin_out, cos_out  out  13 each  signed Q2.10 results.
REQ-012 SHALL have port err_out  out  1  only when CORDIC_RANGE_CHECK_EN is defined (see Configuration).

Function
REQ-013 SHALL use constants PI = 3217 and HALF_PI = 1608 (Q2.10 codes).
REQ-014 SHALL implement FSM IDLE -> FOLD -> KICK -> WAIT -> FIX -> IDLE.
REQ-015 IDLE: start=1 SHALL capture phase_in and go to FOLD; start in any other state SHALL be ignored.
REQ-016 FOLD (1 cycle): a = |phase|; sin_neg = (phase<0); if a > HALF_PI then a = PI - a and cos_neg = 1, else cos_neg = 0; register a[11:0] into core_angle.
REQ-017 KICK (1 cycle): core_start SHALL be 1 for exactly this cycle; core_angle SHALL stay stable from KICK until leaving WAIT.
REQ-018 WAIT: core_ready=1 SHALL register core_sin/core_cos and go to FIX; a 6-bit counter SHALL count WAIT cycles.
REQ-019 WAIT timeout: counter reaching ITER_TIMEOUT without core_ready SHALL go to FIX with both results forced to 0.
REQ-020 FIX (1 cycle): sin_out = sin_neg ? -core_sin : +core_sin; cos_out likewise with cos_neg; operands zero-extended to 13 bits before negation; ready_out = 1 this cycle.
REQ-021 sin_out/cos_out SHALL hold their value until the next FIX or reset.
REQ-022 Latency: ready_out SHALL assert exactly 2 cycles after the cycle in which core_ready is sampled high, and no earlier than 4 cycles after start.
REQ-023 phase_in = 0 SHALL give sin_neg = 0; a = HALF_PI exactly SHALL not fold; a = PI SHALL fold to 0 with cos_neg = 1.
REQ-024 Back-to-back: start in the cycle ready_out is high SHALL be ignored; start one cycle later SHALL be accepted.

Reset
REQ-025 While reset=1: FSM SHALL enter IDLE; core_start, ready_out, err_out, and the counter SHALL be 0; core_angle, sin_out, and cos_out SHALL be 0.
REQ-026 Reset asserted in any state, including mid-WAIT, SHALL abort the operation with no ready_out pulse; a later core_ready SHALL be ignored while IDLE.

Configuration
REQ-027 Macro CORDIC_RANGE_CHECK_EN defined: err_out exists. If |phase_in| > PI in FOLD, the block SHALL skip KICK/WAIT and go to FIX, with results 0, err_out = 1 together with ready_out, and no core_start. err_out SHALL also be 1 on timeout.
REQ-028 Macro undefined: no err_out port. |phase_in| > PI SHALL be saturated to PI before folding. Timeout SHALL still zero the results.

Verification
REQ-029 phase_in = 717 (0.7 rad), core model returns sin 660 / cos 783 after 16 cycles -> core_angle = 717, one core_start pulse, sin_out = +660, cos_out = +783.
REQ-030 phase_in = -717 -> core_angle = 717, sin_out = -660, cos_out = +783.
REQ-031 phase_in = 2500 -> core_angle = 717, sin_out = +660, cos_out = -783; phase_in = -2500 -> sin_out = -660, cos_out = -783.
REQ-032 phase_in = 3300 -> with macro: ready_out 2 cycles after FOLD, err_out = 1, outputs 0, no core_start; without macro: core_angle = 0, cos_out = -1024 when the model returns cos 1024.
REQ-033 Reset pulsed during WAIT, then core_ready raised -> no ready_out, FSM IDLE, outputs 0; model never asserts core_ready -> ready_out at WAIT+63 with results 0.
REQ-034 start held high for 30 cycles -> exactly one core_start per accepted request; start during ready_out ignored.
